// File: rtl/ddio_ctrl_pkg.sv
// ddio_ctrl_pkg: shared FSM state encoding, counter width and PRBS7 helpers for the DDIO output sequencer
package ddio_ctrl_pkg;
   typedef enum logic [2:0] {
      RST_HOLD = 3'd0,
      SETTLE   = 3'd1,
      TRAIN    = 3'd2,
      IDLE     = 3'd3,
      DATA     = 3'd4
   } state_e;
   localparam int CNT_W = 16;
   localparam logic [6:0] PRBS_SEED = 7'h7F;
   // x^7 + x^6 + 1: feedback from the two oldest bits
   localparam logic [6:0] PRBS_TAPS = 7'b110_0000;
   function automatic logic [6:0] prbs_step(input logic [6:0] s);
      return {s[5:0], ^(s & PRBS_TAPS)};
   endfunction
endpackage

// File: rtl/ddio_sync_2ff.sv
// ddio_sync_2ff: two-flop synchronizer, async active-high reset to 0
//   clk_i  : destination clock
//   arst_i : asynchronous active-high reset
//   d_i    : asynchronous input
//   q_o    : synchronized output (2 clk_i cycles of latency)
module ddio_sync_2ff (
   input  logic clk_i,
   input  logic arst_i,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] sync_q;
   always_ff @(posedge clk_i or posedge arst_i)
      if (arst_i) sync_q <= '0;
      else        sync_q <= {sync_q[0], d_i};
   assign q_o = sync_q[1];
endmodule

// File: rtl/ddio_out_seq_ctrl.sv
// ddio_out_seq_ctrl: sequences one DDIO output lane group through x2 reset, settle, training and user data
//   c_x1 / arst_c_x1        : x1 clock, async active-high reset
//   pll_lock                : raw PLL lock (synchronized internally)
//   tx_en, s_d0/s_d1, s_valid, s_ready : user data phase and handshake
//   ddio_d0/ddio_d1, ddio_lock, arst_c_x2_req : serializer controls
//   state                   : current FSM state code
//   err_unlock / err_clr    : sticky loss-of-lock flag and its clear
//   Macro DDIO_OUT_PRBS_TRAIN_EN selects a PRBS7 training pattern instead of fixed 1/0.
module ddio_out_seq_ctrl
   import ddio_ctrl_pkg::*;
#(
   parameter int   DW         = 8,
   parameter logic INIT       = 1'b0,
   parameter int   SETTLE_CYC = 64,
   parameter int   TRAIN_LEN  = 16
) (
   input  logic          c_x1,
   input  logic          arst_c_x1,
   input  logic          pll_lock,
   input  logic          tx_en,
   input  logic [DW-1:0] s_d0,
   input  logic [DW-1:0] s_d1,
   input  logic          s_valid,
   output logic          s_ready,
   output logic [DW-1:0] ddio_d0,
   output logic [DW-1:0] ddio_d1,
   output logic          ddio_lock,
   output logic          arst_c_x2_req,
   output logic [2:0]    state,
   output logic          err_unlock,
   input  logic          err_clr
);
   logic             lock_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    d0_q, d0_d, d1_q, d1_d;
   logic             lock_q, lock_d, req_q, req_d, err_q, err_d;
   logic             pat0, pat1;

   ddio_sync_2ff u_lock_sync (
      .clk_i (c_x1),
      .arst_i(arst_c_x1),
      .d_i   (pll_lock),
      .q_o   (lock_s)
   );

`ifdef DDIO_OUT_PRBS_TRAIN_EN
   logic [6:0] lfsr_q, lfsr_d, lfsr_src, lfsr_mid;
   // the first TRAIN cycle is emitted from the seed, so entry restarts the sequence
   always_comb begin
      lfsr_src = (state_q == TRAIN) ? lfsr_q : PRBS_SEED;
      lfsr_mid = prbs_step(lfsr_src);
      lfsr_d   = prbs_step(lfsr_mid);
      pat0     = lfsr_mid[0];
      pat1     = lfsr_d[0];
   end
   always_ff @(posedge c_x1 or posedge arst_c_x1)
      if (arst_c_x1) lfsr_q <= '0;
      else           lfsr_q <= lfsr_d;
`else
   assign pat0 = 1'b1;
   assign pat1 = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_clr ? 1'b0 : err_q;
      case (state_q)
         RST_HOLD: if (lock_s) begin
            state_d = SETTLE;
            cnt_d   = '0;
         end
         SETTLE: if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
            state_d = TRAIN;
            cnt_d   = '0;
         end else cnt_d = cnt_q + 1'b1;
         TRAIN: if (cnt_q == CNT_W'(TRAIN_LEN - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else cnt_d = cnt_q + 1'b1;
         IDLE:    state_d = tx_en ? DATA : IDLE;
         DATA:    state_d = tx_en ? DATA : IDLE;
         default: state_d = RST_HOLD;
      endcase
      // lock loss overrides everything; set wins over a simultaneous clear
      if (state_q != RST_HOLD && !lock_s) begin
         state_d = RST_HOLD;
         cnt_d   = '0;
         err_d   = 1'b1;
      end
      req_d  = state_d == RST_HOLD;
      lock_d = state_d inside {TRAIN, IDLE, DATA};
      d0_d   = {DW{INIT}};
      d1_d   = {DW{INIT}};
      // outputs follow the next state so they line up with the state code
      if (state_d == TRAIN) begin
         d0_d = {DW{pat0}};
         d1_d = {DW{pat1}};
      end else if (state_q == DATA && s_valid && lock_s) begin
         d0_d = s_d0;
         d1_d = s_d1;
      end
   end

   always_ff @(posedge c_x1 or posedge arst_c_x1)
      if (arst_c_x1) begin
         state_q <= RST_HOLD;
         cnt_q   <= '0;
         d0_q    <= {DW{INIT}};
         d1_q    <= {DW{INIT}};
         lock_q  <= 1'b0;
         req_q   <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         lock_q  <= lock_d;
         req_q   <= req_d;
         err_q   <= err_d;
      end

   assign s_ready       = state_q == DATA;
   assign ddio_d0       = d0_q;
   assign ddio_d1       = d1_q;
   assign ddio_lock     = lock_q;
   assign arst_c_x2_req = req_q;
   assign state         = state_q;
   assign err_unlock    = err_q;
endmodule

// File: tb/tb_ddio_out_seq_ctrl.sv
// tb_ddio_out_seq_ctrl: scoreboard bench for the DDIO output sequencer
module tb_ddio_out_seq_ctrl;
   localparam int DW = 8;
   localparam int S  = 4;
`ifdef DDIO_OUT_PRBS_TRAIN_EN
   localparam int T  = 8;
`else
   localparam int T  = 3;
`endif
   typedef struct packed {
      logic [2:0]    st;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          lk;
      logic          rq;
      logic          rdy;
      logic          err;
   } exp_t;

   logic          c_x1 = 1'b0, arst_c_x1 = 1'b1, pll_lock = 1'b0, tx_en = 1'b0;
   logic          s_valid = 1'b0, err_clr = 1'b0;
   logic [DW-1:0] s_d0 = '0, s_d1 = '0;
   logic          s_ready, ddio_lock, arst_c_x2_req, err_unlock;
   logic [DW-1:0] ddio_d0, ddio_d1;
   logic [2:0]    state;

   exp_t exp_q[$];
   int   errors = 0, checks = 0;
   bit   prbs[0:2*T+6];
   bit   ls1, ls2, m_err;
   int   p;
   logic [2:0] ps;

   always #5 c_x1 = ~c_x1;

   ddio_out_seq_ctrl #(.DW(DW), .INIT(1'b0), .SETTLE_CYC(S), .TRAIN_LEN(T)) dut (
      .c_x1(c_x1), .arst_c_x1(arst_c_x1), .pll_lock(pll_lock), .tx_en(tx_en),
      .s_d0(s_d0), .s_d1(s_d1), .s_valid(s_valid), .s_ready(s_ready),
      .ddio_d0(ddio_d0), .ddio_d1(ddio_d1), .ddio_lock(ddio_lock),
      .arst_c_x2_req(arst_c_x2_req), .state(state), .err_unlock(err_unlock),
      .err_clr(err_clr)
   );

   // Timeline model: p counts consecutive edges with synchronized lock high;
   // the phase follows from p alone, except IDLE/DATA which follow tx_en.
   task automatic model_step();
      exp_t e;
      bit lp, acc;
      lp  = ls2;
      acc = (ps == 3'd4) && s_valid && lp;
      if (!lp && p > 0) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      p = lp ? p + 1 : 0;
      if (p == 0)                   e.st = 3'd0;
      else if (p <= S)              e.st = 3'd1;
      else if (p <= S + T)          e.st = 3'd2;
      else if (ps >= 3'd3 && tx_en) e.st = 3'd4;
      else                          e.st = 3'd3;
      e.d0 = '0;
      e.d1 = '0;
      if (e.st == 3'd2) begin
`ifdef DDIO_OUT_PRBS_TRAIN_EN
         e.d0 = {DW{prbs[7 + 2*(p-S-1)]}};
         e.d1 = {DW{prbs[8 + 2*(p-S-1)]}};
`else
         e.d0 = '1;
`endif
      end else if (acc) begin
         e.d0 = s_d0;
         e.d1 = s_d1;
      end
      e.lk  = e.st inside {3'd2, 3'd3, 3'd4};
      e.rq  = e.st == 3'd0;
      e.rdy = e.st == 3'd4;
      e.err = m_err;
      exp_q.push_back(e);
      ls2 = ls1;
      ls1 = pll_lock;
      ps  = e.st;
   endtask

   task automatic cycle(input bit pl, te, sv, input logic [DW-1:0] a, b, input bit ec);
      @(negedge c_x1);
      pll_lock = pl; tx_en = te; s_valid = sv; s_d0 = a; s_d1 = b; err_clr = ec;
      model_step();
   endtask

   task automatic chk_reset();
      checks++;
      if ({state, ddio_d0, ddio_d1, ddio_lock, arst_c_x2_req, s_ready, err_unlock} !==
          {3'd0, {DW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset: got st=%0d d0=%h d1=%h lock=%b req=%b rdy=%b err=%b, want st=0 d0=00 d1=00 lock=0 req=1 rdy=0 err=0",
                  state, ddio_d0, ddio_d1, ddio_lock, arst_c_x2_req, s_ready, err_unlock);
      end
   endtask

   task automatic do_reset();
      @(negedge c_x1);
      pll_lock = 1'b0; tx_en = 1'b0; s_valid = 1'b0; err_clr = 1'b0;
      arst_c_x1 = 1'b1;
      exp_q.delete();
      #1 chk_reset();
      repeat (2) @(negedge c_x1);
      arst_c_x1 = 1'b0;
      ls1 = 1'b0; ls2 = 1'b0; p = 0; ps = 3'd0; m_err = 1'b0;
      model_step();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge c_x1);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({state, ddio_d0, ddio_d1, ddio_lock, arst_c_x2_req, s_ready, err_unlock} !== e) begin
               errors++;
               $display("FAIL seq t=%0t: got st=%0d d0=%h d1=%h lock=%b req=%b rdy=%b err=%b, want st=%0d d0=%h d1=%h lock=%b req=%b rdy=%b err=%b",
                        $time, state, ddio_d0, ddio_d1, ddio_lock, arst_c_x2_req, s_ready, err_unlock,
                        e.st, e.d0, e.d1, e.lk, e.rq, e.rdy, e.err);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 7; i++) prbs[i] = 1'b1;
      for (int i = 7; i <= 2*T+6; i++) prbs[i] = prbs[i-7] ^ prbs[i-6];
      repeat (3) @(negedge c_x1);
      #1 chk_reset();
      do_reset();
      repeat (50) cycle(0, 0, 0, 8'h00, 8'h00, 0);
      repeat (12) cycle(1, 0, 0, 8'h00, 8'h00, 0);
      cycle(1, 1, 0, 8'h00, 8'h00, 0);
      cycle(1, 1, 1, 8'hA5, 8'h5A, 0);
      cycle(1, 1, 0, 8'hFF, 8'hFF, 0);
      cycle(1, 1, 1, 8'h3C, 8'hC3, 0);
      cycle(1, 0, 1, 8'h11, 8'h22, 0);
      repeat (2) cycle(1, 0, 0, 8'h00, 8'h00, 0);
      repeat (2) cycle(1, 1, 1, 8'h77, 8'h88, 0);
      repeat (3) cycle(0, 1, 1, 8'h99, 8'h66, 0);
      cycle(0, 1, 0, 8'h00, 8'h00, 1);
      repeat (15) cycle(1, 1, 0, 8'h00, 8'h00, 0);
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 79) != 0, $urandom_range(0, 3) != 0, 1'($urandom()),
               8'($urandom()), 8'($urandom()), $urandom_range(0, 15) == 0);
      do_reset();
      for (int i = 0; i < 30; i++)
         cycle(1, 1, 1'($urandom()), 8'($urandom()), 8'($urandom()), 0);
      repeat (3) @(negedge c_x1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
